// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: walks a wrapping register-file range, folds each entry
// through an external max comparator and writes the maximum back.
module max_scan_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   input  logic [ADDR_W-1:0] dest,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W-1:0] RdAddr,
   input  logic [DATA_W-1:0] RdData,
   output logic [DATA_W-1:0] CmpA,
   output logic [DATA_W-1:0] CmpB,
   output logic              CmpStart,
   input  logic [DATA_W-1:0] CmpOut,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [DATA_W-1:0] WrData
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_CMP,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] dest_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rem_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] cmp_a_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              busy_q;
   logic              done_q;
   logic              cmp_start_q;
   logic              wr_en_q;

   logic [ADDR_W:0]   len_d;
   logic [ADDR_W:0]   rem_d;
   logic [ADDR_W-1:0] ptr_d;

   // Any length with the MSB set is at least the depth: clamp to a full sweep.
   assign len_d = len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : len;
   assign ptr_d = ptr_q + ADDR_W'(1);
   assign rem_d = rem_q - (ADDR_W+1)'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         dest_q      <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         acc_q       <= '0;
         hold_q      <= '0;
         result_q    <= '0;
         cmp_a_q     <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmp_start_q <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         cmp_start_q <= 1'b0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  ptr_q  <= base;
                  dest_q <= dest;
                  len_q  <= len_d;
                  busy_q <= 1'b1;
                  if (len_d == '0) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= '0;
                  end else begin
                     state_q   <= S_LOAD;
                     rd_addr_q <= base;
                  end
               end
            end
            S_LOAD: begin
               acc_q <= RdData;
               ptr_q <= ptr_d;
               rem_q <= len_q - (ADDR_W+1)'(1);
               if (len_q == (ADDR_W+1)'(1)) begin
                  state_q   <= S_WRITE;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= dest_q;
                  wr_data_q <= RdData;
               end else begin
                  state_q   <= S_READ;
                  rd_addr_q <= ptr_d;
               end
            end
            S_READ: begin
               hold_q      <= RdData;
               ptr_q       <= ptr_d;
               cmp_a_q     <= acc_q;
               cmp_start_q <= 1'b1;
               state_q     <= S_CMP;
            end
            S_CMP: begin
               acc_q <= CmpOut;
               rem_q <= rem_d;
               if (rem_d == '0) begin
                  state_q   <= S_WRITE;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= dest_q;
                  wr_data_q <= CmpOut;
               end else begin
                  state_q   <= S_READ;
                  rd_addr_q <= ptr_q;
               end
            end
            S_WRITE: begin
               state_q  <= S_DONE;
               done_q   <= 1'b1;
               result_q <= acc_q;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign RdAddr   = rd_addr_q;
   assign CmpA     = cmp_a_q;
   assign CmpB     = hold_q;
   assign CmpStart = cmp_start_q;
   assign WrEn     = wr_en_q;
   assign WrAddr   = wr_addr_q;
   assign WrData   = wr_data_q;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed scans checked cycle by cycle against a
// scan-level model, with a register file and comparator around the DUT.
module tb_max_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       go = 1'b0;
   logic [2:0] base = '0;
   logic [2:0] dest = '0;
   logic [3:0] len = '0;
   logic       busy, done, CmpStart, WrEn;
   logic [3:0] result, RdData, CmpA, CmpB, CmpOut, WrData;
   logic [2:0] RdAddr, WrAddr;

   logic [3:0] regs [8];
   logic [3:0] init_regs [8];
   logic       load = 1'b0;

   int total = 0;
   int bad = 0;
   int n_cmp = 0;
   int n_wr = 0;

   max_scan_ctrl #(.ADDR_W(3), .DATA_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .go(go),
      .base(base), .len(len), .dest(dest),
      .busy(busy), .done(done), .result(result),
      .RdAddr(RdAddr), .RdData(RdData),
      .CmpA(CmpA), .CmpB(CmpB), .CmpStart(CmpStart), .CmpOut(CmpOut),
      .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
   );

   always #5 clk = ~clk;

   assign RdData = regs[RdAddr];
   assign CmpOut = (CmpA >= CmpB) ? CmpA : CmpB;

   always @(posedge clk) begin
      if (load) regs <= init_regs;
      else if (WrEn) regs[WrAddr] <= WrData;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Scan-level model: what was accepted, how far along, and its snapshot.
   bit         m_act = 1'b0;
   int         m_k = 0;
   int         m_L = 0;
   int         m_b = 0;
   int         m_d = 0;
   int         m_res = 0;
   logic [3:0] m_snap [8];

   function automatic int last_cyc(input int l);
      return (l == 0) ? 1 : 2 * l + 1;
   endfunction

   function automatic int span_max(input int b, input int j);
      int m = 0;
      for (int i = 0; i < j; i++)
         if (int'(m_snap[(b + i) % 8]) > m) m = int'(m_snap[(b + i) % 8]);
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 1'b0;
         m_k   <= 0;
         m_res <= 0;
      end else if (!m_act) begin
         if (go) begin
            m_act  <= 1'b1;
            m_k    <= 1;
            m_L    <= (len > 4'd8) ? 8 : int'(len);
            m_b    <= int'(base);
            m_d    <= int'(dest);
            m_snap <= regs;
         end
      end else if (m_k == last_cyc(m_L)) begin
         m_act <= 1'b0;
         m_res <= span_max(m_b, m_L);
      end else begin
         m_k <= m_k + 1;
      end
   end

   int c_e, c_j;
   bit c_cs, c_we;

   always @(negedge clk) begin
      if (rst_n) begin
         if (CmpStart) n_cmp++;
         if (WrEn) n_wr++;
         if (m_act) begin
            c_e  = last_cyc(m_L);
            c_we = (m_L > 0) && (m_k == c_e - 1);
            c_cs = (m_L > 1) && (m_k % 2 == 1) && (m_k >= 3) && (m_k <= 2 * m_L - 1);
            chk("busy", int'(busy), 1);
            chk("done", int'(done), int'(m_k == c_e));
            chk("wr_en", int'(WrEn), int'(c_we));
            chk("cmp_start", int'(CmpStart), int'(c_cs));
            chk("result", int'(result), (m_k == c_e) ? span_max(m_b, m_L) : m_res);
            if (c_we) begin
               chk("wr_addr", int'(WrAddr), m_d);
               chk("wr_data", int'(WrData), span_max(m_b, m_L));
            end
            if (c_cs) begin
               c_j = (m_k - 1) / 2;
               chk("cmp_b", int'(CmpB), int'(m_snap[(m_b + c_j) % 8]));
               chk("cmp_a", int'(CmpA), span_max(m_b, c_j));
            end
            if (m_L > 0 && (m_k == 1 || (m_k % 2 == 0 && m_k <= 2 * m_L - 2)))
               chk("rd_addr", int'(RdAddr), (m_b + m_k / 2) % 8);
         end else begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_wr_en", int'(WrEn), 0);
            chk("idle_cmp_start", int'(CmpStart), 0);
            chk("idle_result", int'(result), m_res);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_result"}, int'(result), 0);
      chk({tag, "_rdaddr"}, int'(RdAddr), 0);
      chk({tag, "_cmpa"}, int'(CmpA), 0);
      chk({tag, "_cmpb"}, int'(CmpB), 0);
      chk({tag, "_cmpstart"}, int'(CmpStart), 0);
      chk({tag, "_wren"}, int'(WrEn), 0);
      chk({tag, "_wraddr"}, int'(WrAddr), 0);
      chk({tag, "_wrdata"}, int'(WrData), 0);
   endtask

   task automatic load_regs();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_done(output int n, output bit seen);
      n = 1;
      seen = 1'b0;
      while (!seen && n <= 40) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done within 40 cycles at %0t", $time);
      end
   endtask

   task automatic run_scan(input logic [2:0] b, input logic [3:0] l,
                           input logic [2:0] d, input int res,
                           input int cyc, input int ncmp);
      int n;
      bit seen;
      @(negedge clk);
      n_cmp = 0;
      n_wr  = 0;
      base  = b;
      len   = l;
      dest  = d;
      go    = 1'b1;
      @(negedge clk);
      go   = 1'b0;
      base = 3'($urandom_range(7));
      len  = 4'($urandom_range(15));
      dest = 3'($urandom_range(7));
      wait_done(n, seen);
      chk("latency", n, cyc);
      chk("scan_result", int'(result), res);
      chk("cmp_pulses", n_cmp, ncmp);
      chk("wr_pulses", n_wr, (cyc > 1) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      int n;
      bit seen;
      #3;
      chk_zero("por");
      #10 rst_n = 1'b1;

      init_regs = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd1, 4'd0, 4'd4, 4'd7};
      load_regs();
      run_scan(3'd0, 4'd8, 3'd5, 9, 17, 7);
      chk("basic_wb", int'(regs[5]), 9);

      init_regs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14, 4'd12};
      load_regs();
      run_scan(3'd6, 4'd4, 3'd7, 14, 9, 3);
      chk("wrap_wb", int'(regs[7]), 14);

      init_regs = '{4'd0, 4'd1, 4'd2, 4'd11, 4'd4, 4'd5, 4'd6, 4'd7};
      load_regs();
      run_scan(3'd3, 4'd1, 3'd0, 11, 3, 0);
      chk("len1_wb", int'(regs[0]), 11);

      run_scan(3'd2, 4'd0, 3'd4, 0, 1, 0);
      chk("len0_nowb", int'(regs[4]), 4);

      init_regs = '{4'd5, 4'd3, 4'd8, 4'd1, 4'd0, 4'd2, 4'd6, 4'd4};
      load_regs();
      run_scan(3'd2, 4'd12, 3'd1, 8, 17, 7);
      chk("sat_wb", int'(regs[1]), 8);

      init_regs = '{default: 4'd15};
      load_regs();
      run_scan(3'd5, 4'd8, 3'd3, 15, 17, 7);
      chk("all15_wb", int'(regs[3]), 15);

      init_regs = '{default: 4'd0};
      load_regs();
      run_scan(3'd1, 4'd5, 3'd2, 0, 11, 4);
      chk("all0_wb", int'(regs[2]), 0);

      // go held high: second scan picks up inputs changed mid-scan.
      init_regs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      load_regs();
      @(negedge clk);
      base = 3'd4;
      len  = 4'd4;
      dest = 3'd0;
      go   = 1'b1;
      @(negedge clk);
      base = 3'd0;
      len  = 4'd2;
      dest = 3'd1;
      wait_done(n, seen);
      chk("ovl1_latency", n, 9);
      chk("ovl1_result", int'(result), 8);
      @(negedge clk);
      chk("ovl_gap_busy", int'(busy), 0);
      @(negedge clk);
      go = 1'b0;
      chk("ovl2_busy", int'(busy), 1);
      wait_done(n, seen);
      chk("ovl2_latency", n, 5);
      chk("ovl2_result", int'(result), 8);
      chk("ovl_wb0", int'(regs[0]), 8);
      chk("ovl_wb1", int'(regs[1]), 8);
      @(negedge clk);

      // Reset in the middle of a scan: no write-back, everything cleared.
      init_regs = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd1, 4'd0, 4'd4, 4'd7};
      load_regs();
      @(negedge clk);
      base = 3'd0;
      len  = 4'd8;
      dest = 3'd5;
      go   = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("midrst");
      n_wr = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_no_wr", n_wr, 0);
      chk("rst_result", int'(result), 0);
      chk("rst_no_wb", int'(regs[5]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/max_scan_ctrl.md
# max_scan_ctrl

Sequencing controller that drives the read side of the 4-bit register file and the start/operand side of the max comparator. On a `go` pulse it walks a contiguous, wrapping address range, reads one entry per step, and feeds each entry to the comparator against a running maximum. It writes the final maximum back to a destination register, then reports completion. It sits between the register file (one async read port, one sync write port) and the combinational comparator, which holds its output while start is low.

## Interface
- `ADDR_W`, 3: register-file address width; depth = 2**ADDR_W = 8.
- `DATA_W`, 4: register data width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `go`  in  1  start request; sampled only in IDLE.
- `base`  in  ADDR_W  first address of the scan range; captured on go.
- `len`  in  ADDR_W+1  number of entries to scan; captured on go.
- `dest`  in  ADDR_W  write-back address; captured on go.
- `busy`  out  1  high from the cycle after go is accepted until the DONE cycle ends.
- `done`  out  1  one-cycle pulse; the result is valid.
- `result`  out  DATA_W  last computed maximum; held until the next done.
- `RdAddr`  out  ADDR_W  register-file read address. The read is combinational.
- `RdData`  in  DATA_W  register-file read data.
- `CmpA`, `CmpB`  out  DATA_W  comparator operands: running max, current entry.
- `CmpStart`  out  1  comparator start.
- `CmpOut`  in  DATA_W  comparator output, the larger of A and B. When A equals B it returns A.
- `WrEn`  out  1  register-file write enable, one cycle.
- `WrAddr`  out  ADDR_W  write address.
- `WrData`  out  DATA_W  write data.

## Operation
- States: IDLE, LOAD, READ, CMP, WRITE, DONE.
- IDLE: if `go`=1, capture base/dest and L = min(len, 8) into registers, and set ptr = base.
  - L = 0: go to DONE. No reads, no write, `result` set to 0.
  - Otherwise: go to LOAD.
- LOAD: `RdAddr`=ptr. Set acc ← `RdData`, ptr ← ptr+1 (mod 8), remaining ← L−1.
  - If remaining was 0, go to WRITE; else go to READ.
- READ: `RdAddr`=ptr. Set hold ← `RdData`, ptr ← ptr+1 (mod 8). Go to CMP.
- CMP: `CmpStart`=1, `CmpA`=acc, `CmpB`=hold. Set acc ← `CmpOut` and decrement remaining.
  - If remaining is now 0, go to WRITE; else go to READ.
- WRITE: `WrEn`=1, `WrAddr`=dest, `WrData`=acc. Go to DONE.
- DONE: `done`=1, `result` ← acc (for L=0, `result` ← 0). Go to IDLE.
- Address arithmetic is modulo 8: base=6, L=4 reads 6,7,0,1.
- `len` values 9..15 saturate to 8. Each address is read exactly once per scan.
- `dest` may lie inside the range. The write happens after all reads, so the scan never observes its own write-back.
- `go` outside IDLE is ignored; there is no queueing. Changes to base/len/dest after capture have no effect.
- Outputs in all non-driving states:
  - `CmpStart`=0, so the comparator holds its last value.
  - `WrEn`=0.
  - `RdAddr`, `CmpA`, `CmpB`, `WrAddr`, `WrData` hold their last registered values.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE. busy, done, result, RdAddr, CmpA, CmpB, CmpStart, WrEn, WrAddr, WrData, acc, hold, ptr all = 0.
- Reset mid-scan aborts immediately. No write is issued and `result` returns to 0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Latency, with go accepted at edge 0:
  - L ≥ 1: LOAD 1 + (READ+CMP) 2·(L−1) + WRITE 1 → `done` is high in cycle 2L+1 after acceptance. Example: L=8 → done in cycle 17.
  - L = 0: `done` is high in cycle 1.
- `busy` is high from cycle 1 through the DONE cycle. It is low in the cycle after `done`, when a new go may be accepted.
- `WrEn` is high exactly one cycle, immediately before `done`.
- The register file must present `RdData` within the same cycle as `RdAddr` (async read).

## Test plan
- Reset: drive rst_n=0 mid-operation, release → all outputs 0, state IDLE, no WrEn pulse.
- Basic scan: regs[0..7]={3,9,2,9,1,0,4,7}, base=0, len=8, dest=5 → done in cycle 17, result=9, one write with regs[5]=9, exactly 7 CmpStart pulses.
- Wrap-around plus in-range dest: regs={1,2,3,4,5,6,14,12}, base=6, len=4, dest=7 → reads 6,7,0,1; result=14; regs[7]=14; done in cycle 9.
- Edge lengths:
  - len=1, base=3, regs[3]=11 → no CmpStart, write 11, done in cycle 3.
  - len=0 → done in cycle 1, result=0, no WrEn.
  - len=12 → behaves as 8.
- Busy/overlap: assert go every cycle during a len=4 scan → only one scan runs. A second scan is accepted only in the cycle after done.
- Ties and extremes: all regs=15 → result=15; all regs=0 → result=0; every write matches the result.
